// File: rtl/types.sv
// Shared flit types for the inter-device link.
package types;

  typedef struct packed {
    logic       is_ack;
    logic [3:0] seq;
    logic [2:0] dest;
  } header_t;

  typedef struct packed {
    header_t     header;
    logic [23:0] payload;
  } flit_t;

endpackage

// File: rtl/interdevice_tx_arbiter_if.sv
// Source handshakes, waiting-ACK status and TX port of the inter-device TX arbiter.
interface interdevice_tx_arbiter_if;

  types::flit_t ack_flit;
  logic         ack_flit_valid;
  logic         ack_flit_ready;

  types::flit_t resend_flit;
  logic         resend_flit_valid;
  logic         resend_flit_ready;

  types::flit_t new_flit;
  logic         new_flit_valid;
  logic         new_flit_ready;

  logic         ack_buffer_full;

  types::flit_t interdevice_tx_flit;
  logic         interdevice_tx_valid;
  logic         interdevice_tx_ready;

  logic [1:0]   tx_src;
  logic         starve_event;

  // Environment side: flit sources, waiting-ACK controller and physical link.
  modport master (
    output ack_flit, ack_flit_valid, input ack_flit_ready,
    output resend_flit, resend_flit_valid, input resend_flit_ready,
    output new_flit, new_flit_valid, input new_flit_ready,
    output ack_buffer_full,
    input  interdevice_tx_flit, interdevice_tx_valid, output interdevice_tx_ready,
    input  tx_src, starve_event
  );

  // Arbiter side.
  modport slave (
    input  ack_flit, ack_flit_valid, output ack_flit_ready,
    input  resend_flit, resend_flit_valid, output resend_flit_ready,
    input  new_flit, new_flit_valid, output new_flit_ready,
    input  ack_buffer_full,
    output interdevice_tx_flit, interdevice_tx_valid, input interdevice_tx_ready,
    output tx_src, starve_event
  );

endinterface

// File: rtl/interdevice_tx_arbiter.sv
// Fixed-priority (ACK > resend > new) TX arbiter with starvation promotion, feeding a
// one-entry output register in front of the inter-device link.
module interdevice_tx_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic                     nocclk,
  input logic                     rst_n,
  interdevice_tx_arbiter_if.slave tx_if
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;
  typedef enum logic [1:0] {
    SrcNone   = 2'd0,
    SrcAck    = 2'd1,
    SrcResend = 2'd2,
    SrcNew    = 2'd3
  } src_e;

  state_e          state_q, state_d;
  types::flit_t    flit_q, flit_d;
  src_e            src_q, src_d;
  logic            starve_q, starve_d;
  logic [CntW-1:0] resend_cnt_q, resend_cnt_d;
  logic [CntW-1:0] new_cnt_q, new_cnt_d;

  logic tx_valid;
  logic load_en;
  logic ack_elig, resend_elig, new_elig;
  logic force_resend, force_new;
  src_e winner;

  assign tx_valid = (state_q == StFull);
  assign load_en  = (state_q == StEmpty) | (tx_valid & tx_if.interdevice_tx_ready);

  assign ack_elig    = tx_if.ack_flit_valid;
  assign resend_elig = tx_if.resend_flit_valid;
  // ACK-type new flits are never tracked, so a full waiting-ACK buffer must not block them.
  assign new_elig    = tx_if.new_flit_valid &
                       (!tx_if.ack_buffer_full | tx_if.new_flit.header.is_ack);

  always_comb begin
    force_resend = resend_elig && (resend_cnt_q == CntMax);
    force_new    = !force_resend && new_elig && (new_cnt_q == CntMax);
    winner       = SrcNone;
    if (force_resend) begin
      winner = SrcResend;
    end else if (force_new) begin
      winner = SrcNew;
    end else if (ack_elig) begin
      winner = SrcAck;
    end else if (resend_elig) begin
      winner = SrcResend;
    end else if (new_elig) begin
      winner = SrcNew;
    end
  end

  assign tx_if.ack_flit_ready    = load_en && (winner == SrcAck);
  assign tx_if.resend_flit_ready = load_en && (winner == SrcResend);
  assign tx_if.new_flit_ready    = load_en && (winner == SrcNew);

  always_comb begin
    state_d      = state_q;
    flit_d       = flit_q;
    src_d        = src_q;
    starve_d     = 1'b0;
    resend_cnt_d = resend_cnt_q;
    new_cnt_d    = new_cnt_q;

    if (load_en) begin
      if (winner != SrcNone) begin
        state_d  = StFull;
        src_d    = winner;
        starve_d = force_resend | force_new;
        case (winner)
          SrcAck:    flit_d = tx_if.ack_flit;
          SrcResend: flit_d = tx_if.resend_flit;
          SrcNew:    flit_d = tx_if.new_flit;
          default:   flit_d = flit_q;
        endcase

        // A grant opportunity is lost only when eligible and another source won.
        if (winner == SrcResend) begin
          resend_cnt_d = '0;
        end else if (resend_elig && (resend_cnt_q != CntMax)) begin
          resend_cnt_d = resend_cnt_q + 1'b1;
        end

        if (winner == SrcNew) begin
          new_cnt_d = '0;
        end else if (new_elig && (new_cnt_q != CntMax)) begin
          new_cnt_d = new_cnt_q + 1'b1;
        end
      end else begin
        state_d = StEmpty;
        src_d   = SrcNone;
      end
    end
  end

  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StEmpty;
      flit_q       <= '0;
      src_q        <= SrcNone;
      starve_q     <= 1'b0;
      resend_cnt_q <= '0;
      new_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      flit_q       <= flit_d;
      src_q        <= src_d;
      starve_q     <= starve_d;
      resend_cnt_q <= resend_cnt_d;
      new_cnt_q    <= new_cnt_d;
    end
  end

  assign tx_if.interdevice_tx_flit  = flit_q;
  assign tx_if.interdevice_tx_valid = tx_valid;
  assign tx_if.tx_src               = src_q;
  assign tx_if.starve_event         = starve_q;

  a_ready_onehot: assert property (@(posedge nocclk) disable iff (!rst_n)
    $onehot0({tx_if.ack_flit_ready, tx_if.resend_flit_ready, tx_if.new_flit_ready}));

  a_stall_stable: assert property (@(posedge nocclk) disable iff (!rst_n)
    (tx_valid && !tx_if.interdevice_tx_ready) |=> ($stable(flit_q) && $stable(src_q)));

endmodule

// File: tb/tb_interdevice_tx_arbiter.sv
// Directed bench for interdevice_tx_arbiter with hand-computed expectations (STARVE_LIMIT=8).
module tb_interdevice_tx_arbiter;

  logic nocclk = 1'b0;
  logic rst_n  = 1'b0;
  int   checks = 0;
  int   errors = 0;

  interdevice_tx_arbiter_if bus ();

  interdevice_tx_arbiter #(.STARVE_LIMIT(8)) dut (
    .nocclk(nocclk),
    .rst_n (rst_n),
    .tx_if (bus)
  );

  always #5 nocclk = ~nocclk;

  function automatic types::flit_t mk_flit(input logic is_ack, input logic [23:0] pl);
    types::flit_t f;
    f.header.is_ack = is_ack;
    f.header.seq    = 4'h3;
    f.header.dest   = 3'h1;
    f.payload       = pl;
    return f;
  endfunction

  types::flit_t f_ack, f_res, f_new, f_new_ack;

  task automatic tick();
    @(posedge nocclk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ack_flit             = f_ack;
    bus.resend_flit          = f_res;
    bus.new_flit             = f_new;
    bus.ack_flit_valid       = 1'b0;
    bus.resend_flit_valid    = 1'b0;
    bus.new_flit_valid       = 1'b0;
    bus.ack_buffer_full      = 1'b0;
    bus.interdevice_tx_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.interdevice_tx_flit !== 32'h0 || bus.starve_event !== 1'b0) begin
      errors++;
      $display("FAIL reset_flit: flit=%h starve=%b, want 0/0",
               bus.interdevice_tx_flit, bus.starve_event);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({bus.interdevice_tx_valid, bus.tx_src, bus.ack_flit_ready, bus.resend_flit_ready,
           bus.new_flit_ready} !== 6'b0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: valid=%b src=%0d rdy=%b%b%b, want all 0", i,
                 bus.interdevice_tx_valid, bus.tx_src, bus.ack_flit_ready,
                 bus.resend_flit_ready, bus.new_flit_ready);
      end
      tick();
    end
  endtask

  task automatic test_priority_starve();
    int exp_src[12]    = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 3, 1, 1};
    logic exp_st[12]   = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
    logic [2:0] exp_rdy;
    types::flit_t exp_f;
    do_reset();
    bus.ack_flit_valid       = 1'b1;
    bus.resend_flit_valid    = 1'b1;
    bus.new_flit_valid       = 1'b1;
    bus.interdevice_tx_ready = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      case (exp_src[i])
        1:       begin exp_rdy = 3'b100; exp_f = f_ack; end
        2:       begin exp_rdy = 3'b010; exp_f = f_res; end
        default: begin exp_rdy = 3'b001; exp_f = f_new; end
      endcase
      checks++;
      if ({bus.ack_flit_ready, bus.resend_flit_ready, bus.new_flit_ready} !== exp_rdy) begin
        errors++;
        $display("FAIL prio_ready[%0d]: got %b want %b", i,
                 {bus.ack_flit_ready, bus.resend_flit_ready, bus.new_flit_ready}, exp_rdy);
      end
      tick();
      checks++;
      if (bus.interdevice_tx_valid !== 1'b1 || bus.tx_src !== 2'(exp_src[i]) ||
          bus.interdevice_tx_flit !== exp_f || bus.starve_event !== exp_st[i]) begin
        errors++;
        $display("FAIL prio_out[%0d]: valid=%b src=%0d flit=%h starve=%b, want 1/%0d/%h/%b",
                 i, bus.interdevice_tx_valid, bus.tx_src, bus.interdevice_tx_flit,
                 bus.starve_event, exp_src[i], exp_f, exp_st[i]);
      end
    end
  endtask

  task automatic test_ack_full_gate();
    do_reset();
    bus.new_flit_valid       = 1'b1;
    bus.ack_buffer_full      = 1'b1;
    bus.interdevice_tx_ready = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      // Second half lets ACKs win so a gated new flit would otherwise accrue starvation.
      bus.ack_flit_valid = (i >= 10);
      #1;
      checks++;
      if (bus.new_flit_ready !== 1'b0 || dut.new_cnt_q !== 4'd0) begin
        errors++;
        $display("FAIL gate[%0d]: new_ready=%b new_cnt=%0d, want 0/0", i,
                 bus.new_flit_ready, dut.new_cnt_q);
      end
      tick();
    end
    bus.ack_flit_valid  = 1'b0;
    bus.ack_buffer_full = 1'b0;
    #1;
    checks++;
    if (bus.new_flit_ready !== 1'b1) begin
      errors++;
      $display("FAIL gate_release_ready: got %b want 1", bus.new_flit_ready);
    end
    tick();
    checks++;
    if (bus.tx_src !== 2'd3 || bus.interdevice_tx_flit !== f_new ||
        bus.interdevice_tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL gate_release_tx: src=%0d flit=%h valid=%b, want 3/%h/1",
               bus.tx_src, bus.interdevice_tx_flit, bus.interdevice_tx_valid, f_new);
    end
  endtask

  task automatic test_stall();
    do_reset();
    bus.resend_flit_valid    = 1'b1;
    bus.interdevice_tx_ready = 1'b1;
    #1;
    checks++;
    if (bus.resend_flit_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_load: resend_ready=%b want 1", bus.resend_flit_ready);
    end
    tick();
    bus.resend_flit_valid    = 1'b0;
    bus.interdevice_tx_ready = 1'b0;
    bus.ack_flit_valid       = 1'b1;
    bus.new_flit_valid       = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.ack_flit_ready !== 1'b0 || bus.new_flit_ready !== 1'b0 ||
          bus.tx_src !== 2'd2 || bus.interdevice_tx_flit !== f_res ||
          bus.interdevice_tx_valid !== 1'b1 || dut.new_cnt_q !== 4'd0) begin
        errors++;
        $display("FAIL stall[%0d]: rdy=%b%b src=%0d flit=%h valid=%b new_cnt=%0d, want 00/2/%h/1/0",
                 i, bus.ack_flit_ready, bus.new_flit_ready, bus.tx_src,
                 bus.interdevice_tx_flit, bus.interdevice_tx_valid, dut.new_cnt_q, f_res);
      end
      tick();
    end
    bus.interdevice_tx_ready = 1'b1;
    #1;
    checks++;
    if (bus.ack_flit_ready !== 1'b1 || bus.new_flit_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_release_ready: ack=%b new=%b want 1/0",
               bus.ack_flit_ready, bus.new_flit_ready);
    end
    tick();
    checks++;
    if (bus.tx_src !== 2'd1 || bus.interdevice_tx_flit !== f_ack || dut.new_cnt_q !== 4'd1) begin
      errors++;
      $display("FAIL stall_release_tx: src=%0d flit=%h new_cnt=%0d want 1/%h/1",
               bus.tx_src, bus.interdevice_tx_flit, dut.new_cnt_q, f_ack);
    end
  endtask

  task automatic test_is_ack_bypass();
    do_reset();
    bus.new_flit             = f_new_ack;
    bus.new_flit_valid       = 1'b1;
    bus.ack_buffer_full      = 1'b1;
    bus.interdevice_tx_ready = 1'b1;
    #1;
    checks++;
    if (bus.new_flit_ready !== 1'b1) begin
      errors++;
      $display("FAIL bypass_ready: got %b want 1", bus.new_flit_ready);
    end
    tick();
    checks++;
    if (bus.tx_src !== 2'd3 || bus.interdevice_tx_flit !== f_new_ack ||
        bus.starve_event !== 1'b0) begin
      errors++;
      $display("FAIL bypass_tx: src=%0d flit=%h starve=%b want 3/%h/0",
               bus.tx_src, bus.interdevice_tx_flit, bus.starve_event, f_new_ack);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.ack_flit_valid       = 1'b1;
    bus.resend_flit_valid    = 1'b1;
    bus.interdevice_tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (dut.resend_cnt_q !== 4'd5 || bus.interdevice_tx_valid !== 1'b1 ||
        bus.tx_src !== 2'd1) begin
      errors++;
      $display("FAIL mid_pre: resend_cnt=%0d valid=%b src=%0d want 5/1/1",
               dut.resend_cnt_q, bus.interdevice_tx_valid, bus.tx_src);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.interdevice_tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_async: valid=%b want 0", bus.interdevice_tx_valid);
    end
    clear_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (dut.resend_cnt_q !== 4'd0 || bus.tx_src !== 2'd0 || bus.interdevice_tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_post: resend_cnt=%0d src=%0d valid=%b want 0/0/0",
               dut.resend_cnt_q, bus.tx_src, bus.interdevice_tx_valid);
    end
  endtask

  initial begin
    f_ack     = mk_flit(1'b1, 24'hAAA001);
    f_res     = mk_flit(1'b0, 24'h5E5002);
    f_new     = mk_flit(1'b0, 24'h0E0003);
    f_new_ack = mk_flit(1'b1, 24'h0E0AC4);
    clear_inputs();
    test_reset();
    test_priority_starve();
    test_ack_full_gate();
    test_stall();
    test_is_ack_bypass();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
